// File: rtl/fifo_ctrl.sv
// FIFO pointer/flag controller driving an external synchronous-read RAM.
// Define FIFO_CTRL_ERR_EN to add sticky overflow/underflow flags with err_clr.
module fifo_ctrl #(
   parameter int AW     = 4,
   parameter int AF_LVL = (2 ** AW) - 2,
   parameter int AE_LVL = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic          rd_en,
`ifdef FIFO_CTRL_ERR_EN
   input  logic          err_clr,
   output logic          ovf,
   output logic          udf,
`endif
   output logic          mem_we,
   output logic [AW-1:0] wr_addr,
   output logic [AW-1:0] rd_addr,
   output logic          rd_valid,
   output logic          full,
   output logic          empty,
   output logic          almost_full,
   output logic          almost_empty,
   output logic [AW:0]   count
);

   localparam logic [AW:0] AF_THR = (AW + 1)'(AF_LVL);
   localparam logic [AW:0] AE_THR = (AW + 1)'(AE_LVL);

   logic [AW:0] wptr;
   logic [AW:0] rptr;
   logic [AW:0] wptr_next;
   logic [AW:0] rptr_next;
   logic [AW:0] count_next;
   logic        wr_acc;
   logic        rd_acc;

   // Acceptance uses the flags registered at the start of the cycle, so a
   // read on empty never sees the same-cycle write.
   always_comb begin
      wr_acc     = wr_en & ~full;
      rd_acc     = rd_en & ~empty;
      mem_we     = wr_acc & ~rst;
      wptr_next  = wptr + {{AW{1'b0}}, wr_acc};
      rptr_next  = rptr + {{AW{1'b0}}, rd_acc};
      count_next = wptr_next - rptr_next;
   end

   assign wr_addr = wptr[AW-1:0];
   assign rd_addr = rptr[AW-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr         <= '0;
         rptr         <= '0;
         count        <= '0;
         empty        <= 1'b1;
         full         <= 1'b0;
         almost_empty <= 1'b1;
         almost_full  <= (AF_THR == '0);
         rd_valid     <= 1'b0;
      end else begin
         wptr         <= wptr_next;
         rptr         <= rptr_next;
         count        <= count_next;
         empty        <= (wptr_next == rptr_next);
         full         <= (wptr_next[AW-1:0] == rptr_next[AW-1:0]) &&
                         (wptr_next[AW] != rptr_next[AW]);
         almost_full  <= (count_next >= AF_THR);
         almost_empty <= (count_next <= AE_THR);
         rd_valid     <= rd_acc;
      end
   end

`ifdef FIFO_CTRL_ERR_EN
   // A new error event wins over a clear issued in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else begin
         if (wr_en & full)
            ovf <= 1'b1;
         else if (err_clr)
            ovf <= 1'b0;
         if (rd_en & empty)
            udf <= 1'b1;
         else if (err_clr)
            udf <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl (AW=2): hand vector table, continuous
// read/write wrap run, then randomized traffic against an occupancy model.
module tb_fifo_ctrl;

   localparam int AW    = 2;
   localparam int DEPTH = 4;
   localparam int AF    = 3;
   localparam int AE    = 1;

   logic          clk;
   logic          rst;
   logic          wr_en;
   logic          rd_en;
   logic          mem_we;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;
   logic          rd_valid;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic [AW:0]   count;
`ifdef FIFO_CTRL_ERR_EN
   logic          err_clr;
   logic          ovf;
   logic          udf;
`endif

   int checks   = 0;
   int failures = 0;

   fifo_ctrl #(.AW(AW), .AF_LVL(AF), .AE_LVL(AE)) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .rd_en        (rd_en),
`ifdef FIFO_CTRL_ERR_EN
      .err_clr      (err_clr),
      .ovf          (ovf),
      .udf          (udf),
`endif
      .mem_we       (mem_we),
      .wr_addr      (wr_addr),
      .rd_addr      (rd_addr),
      .rd_valid     (rd_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit wr, rd, rs, clr;
      bit we;
      int cnt;
      bit fl, em, af, ae, rv;
      int wa;
      bit ov, ud;
   } vec_t;

   vec_t vecs[16];

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // Inputs change on the falling edge; combinational outputs settle 1 time unit later.
   task automatic applyStimulus(input bit wr, input bit rd, input bit rs, input bit clr);
      @(negedge clk);
      wr_en = wr;
      rd_en = rd;
      rst   = rs;
`ifdef FIFO_CTRL_ERR_EN
      err_clr = clr;
`else
      if (clr) begin end
`endif
      #1;
   endtask

   task automatic nextEdge();
      @(posedge clk);
      #1;
   endtask

   // Twenty cycles of simultaneous read+write at occupancy 2; pointers start at w=6, r=4.
   task automatic continuousRun();
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
         checkOutput("cont_mem_we", mem_we, 1);
         nextEdge();
         checkOutput("cont_count", count, 2);
         checkOutput("cont_full", full, 0);
         checkOutput("cont_empty", empty, 0);
         checkOutput("cont_af", almost_full, 0);
         checkOutput("cont_ae", almost_empty, 0);
         checkOutput("cont_rv", rd_valid, 1);
         checkOutput("cont_wr_addr", wr_addr, (7 + i) % DEPTH);
         checkOutput("cont_rd_addr", rd_addr, (5 + i) % DEPTH);
      end
   endtask

   task automatic randomPhase();
      int  wtot = 0;
      int  rtot = 0;
      int  occ;
      int  wprob;
      bit  rvm = 0;
      bit  ovm = 0;
      bit  udm = 0;
      bit  wr, rd, rs, clr, wa, ra;
      for (int n = 0; n < 400; n++) begin
         wprob = ((n / 50) % 2 == 0) ? 75 : 25;
         wr  = ($urandom_range(0, 99) < wprob);
         rd  = ($urandom_range(0, 99) < (100 - wprob));
         rs  = (n == 0) || ($urandom_range(0, 63) == 0);
         clr = ($urandom_range(0, 7) == 0);
         applyStimulus(wr, rd, rs, clr);
         occ = wtot - rtot;
         checkOutput("rnd_mem_we", mem_we, (!rs && wr && occ < DEPTH) ? 1 : 0);
         checkOutput("rnd_wr_addr", wr_addr, wtot % DEPTH);
         checkOutput("rnd_rd_addr", rd_addr, rtot % DEPTH);
         if (rs) begin
            wtot = 0; rtot = 0; rvm = 0; ovm = 0; udm = 0;
         end else begin
            wa = wr && occ < DEPTH;
            ra = rd && occ > 0;
            if (wr && occ == DEPTH) ovm = 1; else if (clr) ovm = 0;
            if (rd && occ == 0) udm = 1; else if (clr) udm = 0;
            wtot += int'(wa);
            rtot += int'(ra);
            rvm = ra;
         end
         occ = wtot - rtot;
         nextEdge();
         checkOutput("rnd_count", count, occ);
         checkOutput("rnd_full", full, (occ == DEPTH) ? 1 : 0);
         checkOutput("rnd_empty", empty, (occ == 0) ? 1 : 0);
         checkOutput("rnd_af", almost_full, (occ >= AF) ? 1 : 0);
         checkOutput("rnd_ae", almost_empty, (occ <= AE) ? 1 : 0);
         checkOutput("rnd_rv", rd_valid, rvm);
`ifdef FIFO_CTRL_ERR_EN
         checkOutput("rnd_ovf", ovf, ovm);
         checkOutput("rnd_udf", udf, udm);
`else
         if (ovm || udm) begin end
`endif
      end
   endtask

   initial begin
      rst   = 1'b1;
      wr_en = 1'b0;
      rd_en = 1'b0;
`ifdef FIFO_CTRL_ERR_EN
      err_clr = 1'b0;
`endif
      //          wr rd rs clr we cnt fl em af ae rv wa ov ud
      vecs[0]  = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
      vecs[1]  = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0};
      vecs[2]  = '{1, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 2, 0, 0};
      vecs[3]  = '{1, 0, 0, 0, 1, 3, 0, 0, 1, 0, 0, 3, 0, 0};
      vecs[4]  = '{1, 0, 0, 0, 1, 4, 1, 0, 1, 0, 0, 0, 0, 0};
      vecs[5]  = '{1, 0, 0, 0, 0, 4, 1, 0, 1, 0, 0, 0, 1, 0};
      vecs[6]  = '{0, 0, 0, 1, 0, 4, 1, 0, 1, 0, 0, 0, 0, 0};
      vecs[7]  = '{1, 1, 0, 0, 0, 3, 0, 0, 1, 0, 1, 0, 1, 0};
      vecs[8]  = '{0, 1, 0, 0, 0, 2, 0, 0, 0, 0, 1, 0, 1, 0};
      vecs[9]  = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 1, 0};
      vecs[10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1, 0};
      vecs[11] = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 1, 1};
      vecs[12] = '{1, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 2, 1, 1};
      vecs[13] = '{1, 0, 0, 0, 1, 3, 0, 0, 1, 0, 0, 3, 1, 1};
      vecs[14] = '{1, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
      vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0};

      for (int i = 0; i < 16; i++) begin
         if (i == 13) continuousRun();
         applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].rs, vecs[i].clr);
         checkOutput($sformatf("v%0d_mem_we", i), mem_we, vecs[i].we);
         nextEdge();
         checkOutput($sformatf("v%0d_count", i), count, vecs[i].cnt);
         checkOutput($sformatf("v%0d_full", i), full, vecs[i].fl);
         checkOutput($sformatf("v%0d_empty", i), empty, vecs[i].em);
         checkOutput($sformatf("v%0d_af", i), almost_full, vecs[i].af);
         checkOutput($sformatf("v%0d_ae", i), almost_empty, vecs[i].ae);
         checkOutput($sformatf("v%0d_rv", i), rd_valid, vecs[i].rv);
         checkOutput($sformatf("v%0d_wr_addr", i), wr_addr, vecs[i].wa);
`ifdef FIFO_CTRL_ERR_EN
         checkOutput($sformatf("v%0d_ovf", i), ovf, vecs[i].ov);
         checkOutput($sformatf("v%0d_udf", i), udf, vecs[i].ud);
`endif
      end

      randomPhase();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter AW, default 4: address width; depth DEPTH = 2^AW entries.
REQ-002 Parameter AF_LVL, default 2^AW-2: almost_full threshold in entries, legal range 1..DEPTH.
REQ-003 Parameter AE_LVL, default 2: almost_empty threshold in entries, legal range 0..DEPTH-1.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 wr_en  in  1  write request.
REQ-007 rd_en  in  1  read request.
REQ-008 mem_we  out  1  write strobe to the storage RAM; high = write accepted this cycle.
REQ-009 wr_addr  out  AW  RAM write address.
REQ-010 rd_addr  out  AW  RAM read address; the RAM is synchronous-read.
REQ-011 rd_valid  out  1  RAM read data valid; high one cycle after an accepted read.
REQ-012 full / empty  out  1 each  registered occupancy flags.
REQ-013 almost_full / almost_empty  out  1 each  registered threshold flags.
REQ-014 count  out  AW+1  current occupancy, 0..DEPTH.
REQ-015 err_clr  in  1  clears sticky error flags; present only with FIFO_CTRL_ERR_EN.
REQ-016 ovf / udf  out  1 each  sticky overflow/underflow; present only with FIFO_CTRL_ERR_EN.

Function
REQ-017 Write pointer wptr and read pointer rptr shall each be AW+1 bits: AW address bits plus one wrap bit; they increment modulo 2^(AW+1).
REQ-018 Write accepted = wr_en & ~full; read accepted = rd_en & ~empty; evaluated against the flags registered at the start of the cycle.
REQ-019 mem_we shall be combinational, equal to write-accepted; wr_addr = wptr[AW-1:0]; rd_addr = rptr[AW-1:0].
REQ-020 On an accepted write, wptr increments at the next edge; on an accepted read, rptr increments at the next edge.
REQ-021 rd_valid shall be a register set to read-accepted of the previous cycle.
REQ-022 count = wptr - rptr in AW+1-bit arithmetic, registered, updated the same edge as the pointers.
REQ-023 empty: wptr == rptr. full: address bits equal and wrap bits differ. Both shall be registered and reflect pointer state after the edge.
REQ-024 almost_full = (count >= AF_LVL); almost_empty = (count <= AE_LVL); registered and updated with count.
REQ-025 Simultaneous accepted read and write: both pointers advance and count/flags do not change.
REQ-026 Full with wr_en & rd_en both high: read accepted, write rejected; next cycle count = DEPTH-1 and full = 0.
REQ-027 Empty with wr_en & rd_en both high: write accepted, read rejected (no write-through); next cycle count = 1 and empty = 0.
REQ-028 Pointer wrap from 2^(AW+1)-1 to 0 shall be seamless; flags stay correct across wrap.

Reset
REQ-029 With rst high at an edge: wptr = rptr = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = (AF_LVL == 0 ? 1 : 0), rd_valid = 0, ovf = udf = 0.
REQ-030 rst shall take priority over all requests; mem_we shall be forced low while rst is high.
REQ-031 Reset mid-operation shall discard all occupancy; no accepted operation shall complete in the reset cycle.

Configuration
REQ-032 Macro FIFO_CTRL_ERR_EN defined: ovf sets on wr_en & full, udf sets on rd_en & empty; both are sticky until err_clr or rst; set takes priority over a simultaneous err_clr.
REQ-033 Macro FIFO_CTRL_ERR_EN undefined: err_clr, ovf, udf ports and their logic shall be absent; all other behaviour is identical.

Verification (AW=2, DEPTH=4, AF_LVL=3, AE_LVL=1)
REQ-034 Reset, then 4 writes -> count 1,2,3,4; almost_empty drops after 2nd; almost_full at 3; full at 4; wr_addr 0,1,2,3.
REQ-035 Full, 5th wr_en -> mem_we=0, count stays 4, ovf=1 (with macro); err_clr -> ovf=0.
REQ-036 Full, wr_en & rd_en -> read only; count=3, full=0, rd_valid=1 next cycle.
REQ-037 Empty, wr_en & rd_en -> write only; count=1, empty=0, rd_valid=0; rd_en on empty -> udf=1.
REQ-038 20 cycles of continuous wr_en & rd_en at count=2 -> count stays 2; pointers wrap past 7 -> 0 with no flag glitch.
REQ-039 rst asserted at count=3 -> next cycle count=0, empty=1, rd_valid=0, ovf=udf=0.
